// File: rtl/gpmc_wb_pkg.sv
// rtl/gpmc_wb_pkg.sv - shared types and constants for the GPMC-to-Wishbone bridge
package gpmc_wb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    WB_WR,
    WB_RD,
    DONE
  } state_t;

  localparam int DEF_ADDR_WIDTH     = 16;
  localparam int DEF_DATA_WIDTH     = 16;
  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_TIMEOUT_CYCLES = 255;

  // Wide enough for any practical bus; the bridge slices its own width off.
  localparam logic [63:0] TIMEOUT_READ_DATA = '1;

endpackage

// File: rtl/gpmc_sync.sv
// rtl/gpmc_sync.sv - generic WIDTH x STAGES flop synchroniser with async active-low reset
module gpmc_sync #(
  parameter int               WIDTH     = 1,
  parameter int               STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  // Shift the whole vector through the chain so every bit sees the same latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= RESET_VAL;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/gpmc_wb_bridge.sv
// rtl/gpmc_wb_bridge.sv - GPMC to Wishbone master bridge (optional ack timeout: GPMC_WB_TIMEOUT_EN)
module gpmc_wb_bridge
  import gpmc_wb_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] gpmc_ad_in,
  output logic [DATA_WIDTH-1:0] gpmc_ad_out,
  output logic                  gpmc_ad_oe,
  input  logic                  gpmc_csn,
  input  logic                  gpmc_advn,
  input  logic                  gpmc_wein,
  input  logic                  gpmc_oen,
  output logic                  gpmc_wait,
  output logic [ADDR_WIDTH-1:0] wbm_adr,
  output logic [DATA_WIDTH-1:0] wbm_dat_o,
  input  logic [DATA_WIDTH-1:0] wbm_dat_i,
  output logic                  wbm_cyc,
  output logic                  wbm_stb,
  output logic                  wbm_we,
  input  logic                  wbm_ack,
  output logic                  proto_err,
  output logic                  timeout_err
);

  localparam int SW = DATA_WIDTH + 4;

  logic [SW-1:0]         sync_q;
  logic [DATA_WIDTH-1:0] ad_s;
  logic                  csn_s, advn_s, wein_s, oen_s;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic                  last_rd_q;
  logic                  proto_err_q;
  logic                  load_addr, load_wdata, proto_hit, to_hit;
  logic                  timeout_fire;

  // Strobes reset to their inactive (high) level so the FSM sees an idle bus.
  gpmc_sync #(
    .WIDTH    (SW),
    .STAGES   (SYNC_STAGES),
    .RESET_VAL({{DATA_WIDTH{1'b0}}, 4'b1111})
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    ({gpmc_ad_in, gpmc_csn, gpmc_advn, gpmc_wein, gpmc_oen}),
    .q    (sync_q)
  );

  assign {ad_s, csn_s, advn_s, wein_s, oen_s} = sync_q;

`ifdef GPMC_WB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt;
  logic            timeout_err_q;

  // Count stb cycles; the counter idles at zero so every new cycle starts fresh.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) to_cnt <= '0;
    else if (wbm_stb) to_cnt <= to_cnt + 1'b1;
    else to_cnt <= '0;
  end

  // Fires in the last allowed stb cycle; an ack in that same cycle still wins.
  assign timeout_fire = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Register the timeout strobe into a single-cycle pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) timeout_err_q <= 1'b0;
    else timeout_err_q <= to_hit;
  end

  assign timeout_err = timeout_err_q;
`else
  // Without the timeout the bridge waits for ack forever; this never fires.
  assign timeout_fire = (TIMEOUT_CYCLES < 0);
  assign timeout_err  = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  end

  // Next-state decode and datapath load strobes.
  always_comb begin
    state_nxt  = state;
    load_addr  = 1'b0;
    load_wdata = 1'b0;
    proto_hit  = 1'b0;
    to_hit     = 1'b0;
    case (state)
      IDLE: begin
        if (!csn_s && !advn_s) begin
          load_addr = 1'b1;
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        if (!advn_s) begin
          load_addr = 1'b1;
        end else if (!wein_s && !oen_s) begin
          proto_hit = 1'b1;
          state_nxt = DONE;
        end else if (!wein_s) begin
          state_nxt = WDATA;
        end else if (!oen_s) begin
          state_nxt = WB_RD;
        end else if (csn_s) begin
          state_nxt = IDLE;
        end
      end
      WDATA: begin
        if (!wein_s) load_wdata = 1'b1;
        else state_nxt = WB_WR;
      end
      WB_WR, WB_RD: begin
        if (wbm_ack) begin
          state_nxt = DONE;
        end else if (timeout_fire) begin
          to_hit    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (csn_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address/data holding registers; adr and dat_o stay frozen during the bus cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      last_rd_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      proto_err_q <= proto_hit;
      if (load_addr) addr_q <= ad_s[ADDR_WIDTH-1:0];
      if (load_wdata) wdata_q <= ad_s;
      if (state == WB_RD && wbm_ack) rdata_q <= wbm_dat_i;
      else if (state == WB_RD && to_hit) rdata_q <= TIMEOUT_READ_DATA[DATA_WIDTH-1:0];
      if (load_addr) last_rd_q <= 1'b0;
      else if (state == WB_RD) last_rd_q <= 1'b1;
    end
  end

  assign wbm_cyc     = (state == WB_WR) || (state == WB_RD);
  assign wbm_stb     = wbm_cyc;
  assign wbm_we      = (state == WB_WR);
  assign wbm_adr     = addr_q;
  assign wbm_dat_o   = wdata_q;
  assign gpmc_wait   = (state == IDLE) || (state == DONE);
  assign gpmc_ad_oe  = (state == DONE) && !oen_s && last_rd_q;
  assign gpmc_ad_out = rdata_q;
  assign proto_err   = proto_err_q;

endmodule
